// File: rtl/submaster_wr_client_pkg.sv
// ----------------------------------------------------------------------------
// submaster_wr_client_pkg
// Shared definitions for the submaster write client:
//   - wr_state_t      : FSM state encoding (ST_ABORT only reachable when the
//                       SUBMASTER_WR_GRANT_TMO_EN build option is defined)
//   - axi_resp_t      : AXI BRESP type
//   - AXI_BURST_INCR  : AWBURST code for incrementing bursts
//   - RESP_*          : AXI response codes
//   - axi_size()      : AWSIZE encoding for a given data bus width
// ----------------------------------------------------------------------------
package submaster_wr_client_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_AW    = 3'd2,
        ST_W     = 3'd3,
        ST_B     = 3'd4,
        ST_DONE  = 3'd5,
        ST_ABORT = 3'd6
    } wr_state_t;

    typedef logic [1:0] axi_resp_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    // AWSIZE is log2 of the number of bytes per beat; the data width is a
    // power of two between 8 and 1024 bits, so at most 128 bytes (code 7).
    function automatic logic [2:0] axi_size(input int unsigned data_w);
        int unsigned bytes;
        logic [2:0]  size;
        bytes = data_w / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/submaster_wr_client_if.sv
// ----------------------------------------------------------------------------
// submaster_wr_client_if
// AXI write channels (AW, W, B) shared between a submaster write client and
// the AXI interconnect.
//   Parameters : ADDR_W, DATA_W, LEN_W
//   AW         : awaddr, awlen, awsize, awburst, awvalid / awready
//   W          : wdata, wstrb, wlast, wvalid / wready
//   B          : bresp, bvalid / bready
//   Modports   : master (client side), slave (interconnect / memory side)
// ----------------------------------------------------------------------------
interface submaster_wr_client_if
    import submaster_wr_client_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);

    logic [ADDR_W-1:0]   awaddr;
    logic [LEN_W-1:0]    awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    axi_resp_t           bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/submaster_wr_client_beat_ctr.sv
// ----------------------------------------------------------------------------
// submaster_wr_beat_ctr
// Holds the latched burst length and counts W beats of the current burst.
//   clk, resetn : clock, async active-low reset
//   load        : latch load_len and restart the beat count
//   load_len    : burst length (beats-1) to latch
//   inc         : one W beat accepted
//   clear       : burst finished, return count to zero
//   len         : latched burst length (drives AWLEN)
//   beat        : current beat index
//   last        : current beat is the final beat (beat == len)
// ----------------------------------------------------------------------------
module submaster_wr_beat_ctr #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             inc,
    input  logic             clear,
    output logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] beat,
    output logic             last
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_q;

    // The counter is the same width as the length field; the final beat is
    // detected by equality and clears the count, so a maximum-length burst
    // reaches its last beat exactly at the all-ones value and never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q  <= '0;
            beat_q <= '0;
        end else begin
            if (load) begin
                len_q <= load_len;
            end
            if (load || clear) begin
                beat_q <= '0;
            end else if (inc) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign len  = len_q;
    assign beat = beat_q;
    assign last = (beat_q == len_q);

endmodule

// File: rtl/submaster_wr_client.sv
// ----------------------------------------------------------------------------
// submaster_wr_client
// Submaster-side client of the 8-way write arbiter. Accepts one local write
// request, asks the arbiter for the bus (start), waits for the one-cycle
// grant pulse, runs one AXI INCR write burst (AW, W beats, B) and pulses
// xfer_done so the arbiter returns to idle.
//
// Build option: SUBMASTER_WR_GRANT_TMO_EN
//   When defined, the grant wait is bounded by GRANT_TMO cycles; on expiry
//   start drops and a one-cycle ABORT state resolves a late grant race.
//   When undefined, the client waits for grant indefinitely and tmo is 0.
//
// Ports:
//   clk, resetn     : clock, async active-low reset
//   req_valid/ready : local write request handshake (ready only in IDLE)
//   req_addr/len    : burst start address, beats-1
//   src_data/valid  : local write data stream
//   src_ready       : a data beat was consumed
//   start / grant   : arbiter request / one-cycle grant pulse
//   xfer_done, resp : one-cycle completion pulse, captured BRESP
//   tmo             : one-cycle grant-timeout pulse
//   busy            : FSM not idle
//   axi             : AXI write channels (master modport)
// ----------------------------------------------------------------------------
module submaster_wr_client
    import submaster_wr_client_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int GRANT_TMO = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [DATA_W-1:0]    src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    output logic                 start,
    input  logic                 grant,
    output logic                 xfer_done,
    output axi_resp_t            resp,
    output logic                 tmo,
    output logic                 busy,
    submaster_wr_client_if.master axi
);

    localparam logic [2:0] AW_SIZE = axi_size(DATA_W);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [ADDR_W-1:0] addr_q;
    axi_resp_t         resp_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat;
    logic              last;
    logic              ctr_load;
    logic              w_hs;

    assign ctr_load = (state == ST_IDLE) && req_valid;
    assign w_hs     = (state == ST_W) && src_valid && axi.wready;

    submaster_wr_beat_ctr #(
        .LEN_W (LEN_W)
    ) u_beat_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (ctr_load),
        .load_len (req_len),
        .inc      (w_hs),
        .clear    (w_hs && last),
        .len      (len_q),
        .beat     (beat),
        .last     (last)
    );

`ifdef SUBMASTER_WR_GRANT_TMO_EN
    localparam int TMO_W = (GRANT_TMO > 1) ? $clog2(GRANT_TMO) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             aborted_q;

    // Grant-wait counter: runs only while requesting, restarts on every
    // entry to REQ. It never wraps because REQ is left when it hits the limit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state == ST_REQ) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(GRANT_TMO - 1));

    // Remembers that DONE was reached through a late grant in ABORT, so the
    // timeout is reported together with the completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= (state == ST_ABORT) && grant;
        end
    end

    assign tmo = ((state == ST_ABORT) && !grant) || ((state == ST_DONE) && aborted_q);
`else
    assign tmo = 1'b0;
`endif

    // State, request address and captured response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            resp_q <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (ctr_load) begin
                addr_q <= req_addr;
            end
            if ((state == ST_B) && axi.bvalid) begin
                resp_q <= axi.bresp;
            end
`ifdef SUBMASTER_WR_GRANT_TMO_EN
            else if ((state == ST_ABORT) && grant) begin
                resp_q <= RESP_SLVERR;
            end
`endif
        end
    end

    // Next-state and handshake decode. All outputs are decoded from the
    // registered state, so start rises the cycle after acceptance and falls
    // on the same edge that consumes the grant. A grant seen in any state
    // other than REQ/ABORT has no effect.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        start       = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        src_ready   = 1'b0;
        axi.bready  = 1'b0;
        xfer_done   = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                start = 1'b1;
                if (grant) begin
                    state_nxt = ST_AW;
                end
`ifdef SUBMASTER_WR_GRANT_TMO_EN
                else if (tmo_hit) begin
                    state_nxt = ST_ABORT;
                end
`endif
            end
            ST_AW: begin
                axi.awvalid = 1'b1;
                if (axi.awready) begin
                    state_nxt = ST_W;
                end
            end
            ST_W: begin
                axi.wvalid = src_valid;
                axi.wlast  = last;
                src_ready  = axi.wready;
                if (w_hs && last) begin
                    state_nxt = ST_B;
                end
            end
            ST_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                xfer_done = 1'b1;
                state_nxt = ST_IDLE;
            end
`ifdef SUBMASTER_WR_GRANT_TMO_EN
            ST_ABORT: begin
                state_nxt = grant ? ST_DONE : ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = AW_SIZE;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wdata   = src_data;
    assign axi.wstrb   = '1;

    assign resp = resp_q;
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_submaster_wr_client.sv
// ----------------------------------------------------------------------------
// tb_submaster_wr_client
// Self-checking bench for submaster_wr_client. Each transaction is driven
// cycle by cycle with randomized stalls; expectations come from the request
// itself (address, length, a pre-generated source data array, the chosen
// BRESP) and the handshake rules, not from the DUT.
// ----------------------------------------------------------------------------
module tb_submaster_wr_client;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 8;
    localparam int GRANT_TMO = 16;
    localparam int BUDGET    = 4000;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              start;
    logic              grant;
    logic              xfer_done;
    logic [1:0]        resp;
    logic              tmo;
    logic              busy;

    int testsRun  = 0;
    int failCount = 0;

    submaster_wr_client_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) axi ();

    submaster_wr_client #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .GRANT_TMO (GRANT_TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .start     (start),
        .grant     (grant),
        .xfer_done (xfer_done),
        .resp      (resp),
        .tmo       (tmo),
        .busy      (busy),
        .axi       (axi)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one complete write request and checks it against the expected
    // burst. Inputs are driven on the falling edge and outputs sampled 1 unit
    // later. 'hold' keeps req_valid high afterwards for back-to-back tests,
    // 'expectImmediate' requires acceptance on the first cycle, and
    // resetAtBeat >= 0 pulls resetn low once that many beats have been seen.
    task automatic applyStimulus(input logic [31:0] addr, input int len, input logic [1:0] bresp,
                                 input int grantDly, input int awStall, input int wStall,
                                 input int srcGap, input bit hold, input bit expectImmediate,
                                 input int resetAtBeat);
        logic [31:0] srcData[$];
        int   cyc = 0, accCyc = -1, grantCyc = -1, grantCountdown = -1, bCountdown = -1;
        int   srcIdx = 0, beats = 0, awCount = 0, awErr = 0, orderErr = 0, wErr = 0;
        int   wlastCount = 0, syncErr = 0, doneCount = 0, startInDone = 0, strayStart = 0;
        bit   armed = 0, bHsDone = 0, finished = 0, didReset = 0;
        logic startAfterAcc = 1'bx, startAtGrant = 1'bx, startAfterGrant = 1'bx;
        logic [1:0] respSeen = 2'bxx;

        for (int i = 0; i <= len; i++) srcData.push_back($urandom);

        while (!finished && cyc < BUDGET) begin
            @(negedge clk);
            req_addr  = addr;
            req_len   = LEN_W'(len);
            req_valid = (accCyc < 0) || hold;
            grant     = 1'b0;
            if (grantCountdown == 0) begin
                grant          = 1'b1;
                grantCountdown = -1;
                grantCyc       = cyc;
            end else if (grantCountdown > 0) begin
                grantCountdown--;
            end else if (grantCyc >= 0 && $urandom_range(0, 9) == 0) begin
                grant = 1'b1;
            end
            axi.awready = ($urandom_range(0, 99) >= awStall);
            axi.wready  = ($urandom_range(0, 99) >= wStall);
            src_valid   = (srcIdx <= len) && ($urandom_range(0, 99) >= srcGap);
            src_data    = (srcIdx <= len) ? srcData[srcIdx] : $urandom;
            if (beats > len && bCountdown < 0) bCountdown = $urandom_range(0, 3);
            axi.bvalid = (bCountdown == 0) && !bHsDone;
            axi.bresp  = bresp;
            if (bCountdown > 0) bCountdown--;
            #1;
            if (accCyc < 0 && req_valid && req_ready) accCyc = cyc;
            if (accCyc >= 0 && cyc == accCyc + 1) startAfterAcc = start;
            if (start && !armed) begin
                armed          = 1;
                grantCountdown = grantDly;
            end
            if (cyc == grantCyc) startAtGrant = start;
            if (grantCyc >= 0 && cyc == grantCyc + 1) startAfterGrant = start;
            if (grantCyc >= 0 && cyc > grantCyc + 1 && start) strayStart++;
            if (axi.wvalid && axi.wready) begin
                if (awCount == 0) orderErr++;
                if (beats > len) wErr++;
                else if (axi.wdata !== srcData[beats] || axi.wlast !== (beats == len) || axi.wstrb !== '1) wErr++;
                if (axi.wlast) wlastCount++;
                beats++;
            end
            if (axi.awvalid && axi.awready) begin
                awCount++;
                if (axi.awaddr !== addr || axi.awlen !== LEN_W'(len) || axi.awsize !== 3'd2 || axi.awburst !== 2'b01) awErr++;
            end
            if ((src_valid && src_ready) !== (axi.wvalid && axi.wready)) syncErr++;
            if (src_valid && src_ready) srcIdx++;
            if (axi.bvalid && axi.bready) bHsDone = 1;
            if (xfer_done) begin
                doneCount++;
                respSeen = resp;
                if (start) startInDone++;
                finished = 1;
            end
            if (resetAtBeat >= 0 && beats == resetAtBeat) begin
                #1 resetn = 1'b0;
                #1;
                checkOutput("reset_async_outputs",
                            32'({start, axi.awvalid, axi.wvalid, axi.bready, xfer_done, tmo, busy, src_ready, req_ready}),
                            32'h1);
                checkOutput("reset_async_resp", 32'(resp), 32'h0);
                req_valid = 1'b0;
                src_valid = 1'b0;
                grant     = 1'b0;
                @(negedge clk);
                resetn   = 1'b1;
                didReset = 1;
                break;
            end
            cyc++;
        end

        if (!didReset) begin
            checkOutput("finished_in_budget", 32'(finished), 32'h1);
            if (expectImmediate) checkOutput("accept_cycle", 32'(accCyc), 32'h0);
            checkOutput("start_after_accept", 32'(startAfterAcc), 32'h1);
            checkOutput("start_at_grant", 32'(startAtGrant), 32'h1);
            checkOutput("start_after_grant", 32'(startAfterGrant), 32'h0);
            checkOutput("start_reasserted", 32'(strayStart), 32'h0);
            checkOutput("aw_count", 32'(awCount), 32'h1);
            checkOutput("aw_fields", 32'(awErr), 32'h0);
            checkOutput("w_before_aw", 32'(orderErr), 32'h0);
            checkOutput("beat_count", 32'(beats), 32'(len + 1));
            checkOutput("wdata_wlast", 32'(wErr), 32'h0);
            checkOutput("wlast_count", 32'(wlastCount), 32'h1);
            checkOutput("src_w_sync", 32'(syncErr), 32'h0);
            checkOutput("done_count", 32'(doneCount), 32'h1);
            checkOutput("resp", 32'(respSeen), 32'(bresp));
            checkOutput("start_in_done", 32'(startInDone), 32'h0);
            if (!hold) begin
                @(negedge clk);
                grant = 1'b0;
                #1;
                checkOutput("post_done_idle", 32'({xfer_done, busy, req_ready}), 32'h1);
            end
        end
    endtask

`ifdef SUBMASTER_WR_GRANT_TMO_EN
    // Grant-timeout scenarios. mode 0: no grant at all; mode 1: grant lands
    // in the cycle after the timeout; mode 2: grant lands on the last REQ
    // cycle and must win. Cycle numbers are relative to acceptance: start is
    // high for GRANT_TMO cycles, the following cycle is the abort decision.
    task automatic tmoTest(input int mode);
        int accCyc = -1, startCycles = 0, tmoCount = 0, tmoCyc = -1, doneCyc = -1, awSeen = 0;
        logic [1:0] respSeen = 2'bxx;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            req_addr    = $urandom;
            req_len     = 8'd3;
            req_valid   = (accCyc < 0);
            grant       = (accCyc >= 0) &&
                          ((mode == 1 && cyc == accCyc + GRANT_TMO + 1) ||
                           (mode == 2 && cyc == accCyc + GRANT_TMO));
            axi.awready = 1'b1;
            axi.wready  = 1'b1;
            axi.bvalid  = 1'b1;
            axi.bresp   = 2'b00;
            src_valid   = 1'b1;
            src_data    = $urandom;
            #1;
            if (accCyc < 0 && req_valid && req_ready) accCyc = cyc;
            if (start) startCycles++;
            if (tmo) begin
                tmoCount++;
                tmoCyc = cyc - accCyc;
            end
            if (xfer_done) begin
                doneCyc  = cyc - accCyc;
                respSeen = resp;
            end
            if (axi.awvalid) awSeen++;
        end
        checkOutput("tmo_start_cycles", 32'(startCycles), 32'(GRANT_TMO));
        checkOutput("tmo_end_idle", 32'(busy), 32'h0);
        if (mode == 0) begin
            checkOutput("tmo_count", 32'(tmoCount), 32'h1);
            checkOutput("tmo_cycle", 32'(tmoCyc), 32'(GRANT_TMO + 1));
            checkOutput("tmo_no_done", 32'(doneCyc), 32'hFFFF_FFFF);
            checkOutput("tmo_no_aw", 32'(awSeen), 32'h0);
        end else if (mode == 1) begin
            checkOutput("abort_tmo_count", 32'(tmoCount), 32'h1);
            checkOutput("abort_tmo_cycle", 32'(tmoCyc), 32'(GRANT_TMO + 2));
            checkOutput("abort_done_cycle", 32'(doneCyc), 32'(GRANT_TMO + 2));
            checkOutput("abort_resp", 32'(respSeen), 32'h2);
            checkOutput("abort_no_aw", 32'(awSeen), 32'h0);
        end else begin
            checkOutput("late_grant_no_tmo", 32'(tmoCount), 32'h0);
            checkOutput("late_grant_aw", 32'(awSeen), 32'h1);
            checkOutput("late_grant_done_cycle", 32'(doneCyc), 32'(GRANT_TMO + 7));
            checkOutput("late_grant_resp", 32'(respSeen), 32'h0);
        end
    endtask
`endif

    // Main sequence: reset, directed scenarios, then a batch of random bursts.
    initial begin
        resetn      = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        src_data    = '0;
        src_valid   = 1'b0;
        grant       = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_outputs",
                    32'({start, axi.awvalid, axi.wvalid, axi.bready, xfer_done, tmo, busy, src_ready, req_ready}),
                    32'h1);
        checkOutput("reset_resp", 32'(resp), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(32'h0000_1000, 3, 2'b00, 1, 0, 0, 0, 0, 0, -1);
        applyStimulus(32'h0000_2000, 0, 2'b01, 2, 20, 50, 40, 0, 0, -1);
        applyStimulus(32'h0001_0000, 255, 2'b10, 3, 30, 30, 20, 0, 0, -1);
        applyStimulus(32'h0000_3000, 3, 2'b00, 1, 0, 0, 0, 0, 0, 2);
        applyStimulus(32'h0000_4000, 3, 2'b11, 1, 10, 10, 10, 0, 0, -1);
        applyStimulus(32'h0000_5000, 2, 2'b00, 0, 0, 0, 0, 1, 0, -1);
        applyStimulus(32'h0000_6000, 1, 2'b01, 1, 0, 0, 0, 1, 1, -1);
        applyStimulus(32'h0000_7000, 4, 2'b00, 2, 0, 0, 0, 0, 1, -1);

        for (int t = 0; t < 8; t++) begin
            applyStimulus($urandom, $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 4), $urandom_range(0, 50), $urandom_range(0, 50),
                          $urandom_range(0, 50), 0, 0, -1);
        end

`ifdef SUBMASTER_WR_GRANT_TMO_EN
        tmoTest(0);
        tmoTest(1);
        tmoTest(2);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
